// File: rtl/mem_sync_top.sv
// Per-bank fully-associative DRAM row cache tracker with host-synchronised allocation.
// Optional hit/miss statistics counters are enabled by defining MEM_SYNC_STATS_EN.
module mem_sync_top #(
   parameter int BGWIDTH    = 2,
   parameter int BANKGROUPS = 2**BGWIDTH,
   parameter int BAWIDTH    = 2,
   parameter int CHWIDTH    = 6,
   parameter int ADDRWIDTH  = 17,
   localparam int BANKSPERGROUP = 2**BAWIDTH
) (
   input  logic                                                   clk,
   input  logic                                                   reset,
   input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][ADDRWIDTH-1:0] RowId,
   input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][4:0]           BankFSM,
   input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                sync,
   output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]   cRowId,
   output logic                                                   stall
`ifdef MEM_SYNC_STATS_EN
   ,
   output logic [31:0]                                            hit_count,
   output logic [31:0]                                            miss_count
`endif
);

   localparam int CHROWS = 2**CHWIDTH;
   localparam int NB     = BANKGROUPS * BANKSPERGROUP;

   localparam logic [4:0] CODE_WRITE = 5'b10010;
   localparam logic [4:0] CODE_READ  = 5'b01011;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ALLOC  = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   logic [NB-1:0] stall_v;
`ifdef MEM_SYNC_STATS_EN
   logic [NB-1:0] hit_ev_v;
   logic [NB-1:0] miss_ev_v;
`endif

   for (genvar gi = 0; gi < BANKGROUPS; gi++) begin : g_grp
      for (genvar bi = 0; bi < BANKSPERGROUP; bi++) begin : g_bank
         state_t               state_q, state_d;
         logic [CHWIDTH-1:0]   ptr_q, ptr_d;
         logic [CHWIDTH-1:0]   crow_q, crow_d;
         logic                 stall_q, stall_d;
         logic [ADDRWIDTH-1:0] row_q, row_d;
         logic [CHROWS-1:0]    valid_q, valid_d;
         logic [ADDRWIDTH-1:0] tag_q [CHROWS];
         logic                 tag_we_s;
         logic                 access_s;
         logic [CHROWS-1:0]    match_s;
         logic                 hit_s;
         logic [CHWIDTH-1:0]   hit_idx_s;

         assign access_s = (BankFSM[gi][bi] == CODE_WRITE) || (BankFSM[gi][bi] == CODE_READ);

         // Tag lookup; entries are unique, so OR-ing matched indices yields the hit index.
         always_comb begin
            match_s   = '0;
            hit_idx_s = '0;
            for (int k = 0; k < CHROWS; k++) begin
               match_s[k] = valid_q[k] && (tag_q[k] == RowId[gi][bi]);
               hit_idx_s  = hit_idx_s | ({CHWIDTH{match_s[k]}} & CHWIDTH'(k));
            end
            hit_s = |match_s;
         end

         // Bank state register.
         always_ff @(posedge clk) begin
            if (reset) begin
               state_q <= ST_IDLE;
            end else begin
               state_q <= state_d;
            end
         end

         // Bank next-state logic; ALLOC is left only through sync.
         always_comb begin
            state_d = state_q;
            case (state_q)
               ST_IDLE: begin
                  if (access_s) begin
                     state_d = hit_s ? ST_ACTIVE : ST_ALLOC;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
               ST_ALLOC: begin
                  if (sync[gi][bi]) begin
                     state_d = ST_ACTIVE;
                  end else begin
                     state_d = ST_ALLOC;
                  end
               end
               ST_ACTIVE: begin
                  if (access_s) begin
                     state_d = ST_ACTIVE;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end

         // Bank datapath/output logic; the missed row is latched at entry to ALLOC.
         always_comb begin
            ptr_d    = ptr_q;
            crow_d   = crow_q;
            stall_d  = stall_q;
            row_d    = row_q;
            valid_d  = valid_q;
            tag_we_s = 1'b0;
            case (state_q)
               ST_IDLE: begin
                  if (access_s && hit_s) begin
                     crow_d = hit_idx_s;
                  end else if (access_s) begin
                     crow_d         = ptr_q;
                     stall_d        = 1'b1;
                     row_d          = RowId[gi][bi];
                     valid_d[ptr_q] = 1'b0;
                  end else begin
                     crow_d = crow_q;
                  end
               end
               ST_ALLOC: begin
                  if (sync[gi][bi]) begin
                     tag_we_s       = 1'b1;
                     valid_d[ptr_q] = 1'b1;
                     ptr_d          = ptr_q + CHWIDTH'(1);
                     stall_d        = 1'b0;
                  end else begin
                     stall_d = 1'b1;
                  end
               end
               ST_ACTIVE: stall_d = 1'b0;
               default:   stall_d = 1'b0;
            endcase
         end

         // Bank datapath registers.
         always_ff @(posedge clk) begin
            if (reset) begin
               ptr_q   <= '0;
               crow_q  <= '0;
               stall_q <= 1'b0;
               row_q   <= '0;
               valid_q <= '0;
            end else begin
               ptr_q   <= ptr_d;
               crow_q  <= crow_d;
               stall_q <= stall_d;
               row_q   <= row_d;
               valid_q <= valid_d;
            end
         end

         // Tag storage; no reset needed because valid bits gate every lookup.
         always_ff @(posedge clk) begin
            if (!reset && tag_we_s) begin
               tag_q[ptr_q] <= row_q;
            end
         end

         assign cRowId[gi][bi]               = crow_q;
         assign stall_v[gi*BANKSPERGROUP+bi] = stall_q;
`ifdef MEM_SYNC_STATS_EN
         assign hit_ev_v[gi*BANKSPERGROUP+bi]  = (state_q == ST_IDLE) && access_s && hit_s;
         assign miss_ev_v[gi*BANKSPERGROUP+bi] = (state_q == ST_IDLE) && access_s && !hit_s;
`endif
      end
   end

   assign stall = |stall_v;

`ifdef MEM_SYNC_STATS_EN
   localparam int SUMW = $clog2(NB + 1);

   logic [31:0]   hit_q, hit_d, miss_q, miss_d;
   logic [SUMW-1:0] hit_sum_s, miss_sum_s;
   logic [32:0]   hit_tmp_s, miss_tmp_s;

   // Sum same-edge events over all banks and add with saturation.
   always_comb begin
      hit_sum_s  = '0;
      miss_sum_s = '0;
      for (int i = 0; i < NB; i++) begin
         hit_sum_s  = hit_sum_s + SUMW'(hit_ev_v[i]);
         miss_sum_s = miss_sum_s + SUMW'(miss_ev_v[i]);
      end
      hit_tmp_s  = {1'b0, hit_q} + 33'(hit_sum_s);
      miss_tmp_s = {1'b0, miss_q} + 33'(miss_sum_s);
      if (hit_tmp_s[32]) begin
         hit_d = 32'hFFFF_FFFF;
      end else begin
         hit_d = hit_tmp_s[31:0];
      end
      if (miss_tmp_s[32]) begin
         miss_d = 32'hFFFF_FFFF;
      end else begin
         miss_d = miss_tmp_s[31:0];
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_q  <= 32'd0;
         miss_q <= 32'd0;
      end else begin
         hit_q  <= hit_d;
         miss_q <= miss_d;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_mem_sync_top.sv
// Directed self-checking bench for mem_sync_top (default parameters, 16 banks, 64 cache rows).
module tb_mem_sync_top;

   localparam logic [4:0] WR = 5'b10010;
   localparam logic [4:0] RD = 5'b01011;

   logic                         clk;
   logic                         reset;
   logic [3:0][3:0][16:0]        row_id;
   logic [3:0][3:0][4:0]         bank_fsm;
   logic [3:0][3:0]              sync_in;
   logic [3:0][3:0][5:0]         c_row_id;
   logic                         stall;
`ifdef MEM_SYNC_STATS_EN
   logic [31:0]                  hit_count;
   logic [31:0]                  miss_count;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int exp_hits = 0;
   int exp_misses = 0;

   mem_sync_top dut (
      .clk     (clk),
      .reset   (reset),
      .RowId   (row_id),
      .BankFSM (bank_fsm),
      .sync    (sync_in),
      .cRowId  (c_row_id),
      .stall   (stall)
`ifdef MEM_SYNC_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Miss on bank idx, wait one ALLOC cycle with BankFSM dropped, sync, return to IDLE.
   task automatic do_miss(input int idx, input logic [16:0] row, input int exp_crow);
      int g = idx / 4;
      int b = idx % 4;
      row_id[g][b]   = row;
      bank_fsm[g][b] = WR;
      tick();
      exp_misses++;
      check_eq($sformatf("miss_stall_b%0d", idx), 32'(stall), 32'd1);
      check_eq($sformatf("miss_crow_b%0d", idx), 32'(c_row_id[g][b]), 32'(exp_crow));
      bank_fsm[g][b] = 5'd0;
      tick();
      check_eq($sformatf("alloc_hold_b%0d", idx), 32'(stall), 32'd1);
      sync_in[g][b] = 1'b1;
      tick();
      check_eq($sformatf("sync_release_b%0d", idx), 32'(stall), 32'd0);
      sync_in[g][b] = 1'b0;
      tick();
      check_eq($sformatf("idle_hold_crow_b%0d", idx), 32'(c_row_id[g][b]), 32'(exp_crow));
   endtask

   task automatic do_hit(input int idx, input logic [16:0] row, input int exp_crow);
      int g = idx / 4;
      int b = idx % 4;
      row_id[g][b]   = row;
      bank_fsm[g][b] = RD;
      tick();
      exp_hits++;
      check_eq($sformatf("hit_stall_b%0d", idx), 32'(stall), 32'd0);
      check_eq($sformatf("hit_crow_b%0d", idx), 32'(c_row_id[g][b]), 32'(exp_crow));
      bank_fsm[g][b] = 5'd0;
      tick();
   endtask

   initial begin
      reset    = 1'b1;
      row_id   = '0;
      bank_fsm = '0;
      sync_in  = '0;
      tick();
      tick();
      reset = 1'b0;
      check_eq("reset_stall", 32'(stall), 32'd0);
      check_eq("reset_crow_00", 32'(c_row_id[0][0]), 32'd0);
      check_eq("reset_crow_33", 32'(c_row_id[3][3]), 32'd0);

      // First allocation and re-read on bank [0][0]
      do_miss(0, 17'h1234, 0);
      do_hit(0, 17'h1234, 0);

      // Every other bank: fresh allocation at entry 0, then a hit
      for (int i = 1; i < 16; i++) begin
         logic [16:0] r;
         r = 17'($urandom);
         do_miss(i, r, 0);
         do_hit(i, r, 0);
      end

      // Fill bank [0][0], then wrap and evict entry 0
      for (int i = 1; i < 64; i++) begin
         do_miss(0, 17'(32'h100 + i), i);
      end
      do_miss(0, 17'h2000, 0);
      do_miss(0, 17'h1234, 1);
      do_hit(0, 17'h102, 2);
      do_hit(0, 17'h2000, 0);

      // sync in IDLE must not disturb anything
      sync_in[0][0] = 1'b1;
      tick();
      sync_in[0][0] = 1'b0;
      check_eq("sync_idle_crow", 32'(c_row_id[0][0]), 32'd0);
      check_eq("sync_idle_stall", 32'(stall), 32'd0);

      // Miss at ptr 2; sync and RowId changes while ACTIVE are ignored
      row_id[0][0]   = 17'h3000;
      bank_fsm[0][0] = RD;
      tick();
      exp_misses++;
      check_eq("act_miss_crow", 32'(c_row_id[0][0]), 32'd2);
      sync_in[0][0] = 1'b1;
      tick();
      check_eq("act_enter_stall", 32'(stall), 32'd0);
      tick();
      check_eq("act_sync_crow", 32'(c_row_id[0][0]), 32'd2);
      check_eq("act_sync_stall", 32'(stall), 32'd0);
      sync_in[0][0] = 1'b0;
      row_id[0][0]  = 17'h3333;
      tick();
      check_eq("act_rowchg_crow", 32'(c_row_id[0][0]), 32'd2);
      bank_fsm[0][0] = 5'd0;
      tick();
      do_hit(0, 17'h3000, 2);
      do_miss(0, 17'h5000, 3);

`ifdef MEM_SYNC_STATS_EN
      check_eq("stats_hits", hit_count, 32'(exp_hits));
      check_eq("stats_misses", miss_count, 32'(exp_misses));
`endif

      // Reset in the middle of an allocation on bank [1][2]
      row_id[1][2]   = 17'h4444;
      bank_fsm[1][2] = WR;
      tick();
      check_eq("pre_reset_stall", 32'(stall), 32'd1);
      check_eq("pre_reset_crow_12", 32'(c_row_id[1][2]), 32'd1);
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      bank_fsm   = '0;
      exp_hits   = 0;
      exp_misses = 0;
      check_eq("rst_alloc_stall", 32'(stall), 32'd0);
      check_eq("rst_alloc_crow_12", 32'(c_row_id[1][2]), 32'd0);
      check_eq("rst_alloc_crow_00", 32'(c_row_id[0][0]), 32'd0);
      tick();
      check_eq("post_reset_idle_stall", 32'(stall), 32'd0);
      do_miss(0, 17'h102, 0);
      do_miss(6, 17'h4444, 0);
      do_miss(0, 17'h1234, 1);
      do_hit(6, 17'h4444, 0);

`ifdef MEM_SYNC_STATS_EN
      check_eq("stats_hits_after_rst", hit_count, 32'(exp_hits));
      check_eq("stats_misses_after_rst", miss_count, 32'(exp_misses));
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_sync_top.md
MEM_SYNC_TOP -- requirements
Module: mem_sync_top

Interface
REQ-001 Parameter BGWIDTH, default 2, bank-group address width.
REQ-002 Parameter BANKGROUPS, default 4 (2**BGWIDTH), number of bank groups.
REQ-003 Parameter BAWIDTH, default 2, bank address width; derived BANKSPERGROUP = 2**BAWIDTH, not overridable.
REQ-004 Parameter CHWIDTH, default 6, cache-row index width; CHROWS = 2**CHWIDTH entries per bank.
REQ-005 Parameter ADDRWIDTH, default 17, DRAM row address width.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 RowId  input  [BANKGROUPS][BANKSPERGROUP] x ADDRWIDTH  per-bank requested DRAM row.
REQ-009 BankFSM  input  [BANKGROUPS][BANKSPERGROUP] x 5  per-bank DRAM bank state code.
REQ-010 sync  input  [BANKGROUPS][BANKSPERGROUP] x 1  per-bank host pulse: row load/evict complete.
REQ-011 cRowId  output  [BANKGROUPS][BANKSPERGROUP] x CHWIDTH  per-bank cache row serving the access, registered.
REQ-012 stall  output  1  OR of all per-bank stall flags, registered.

Function
REQ-013 Each bank SHALL hold an independent fully-associative table of CHROWS entries {valid, tag[ADDRWIDTH-1:0]}, plus a CHWIDTH-bit allocation pointer ptr.
REQ-014 Access codes: WRITE = 5'b10010, READ = 5'b01011; any other BankFSM value is non-access.
REQ-015 Per-bank FSM states: IDLE, ALLOC, ACTIVE.
REQ-016 IDLE with access code: lookup RowId against valid tags same cycle; hit at index k -> next edge ACTIVE, cRowId<=k, bank stall stays 0.
REQ-017 IDLE with access code and miss -> next edge ALLOC, cRowId<=ptr, bank stall<=1, entry ptr valid<=0.
REQ-018 ALLOC: remain (stall=1) until sync=1 at an edge; on that edge tag[ptr]<=RowId captured at entry, valid[ptr]<=1, ptr<=ptr+1 mod CHROWS, stall<=0, state<=ACTIVE.
REQ-019 ALLOC SHALL NOT leave on BankFSM changes; only sync or reset exits it.
REQ-020 ACTIVE: hold cRowId; return to IDLE on first edge where BankFSM is non-access; RowId changes while ACTIVE ignored.
REQ-021 sync outside ALLOC ignored.
REQ-022 Table full: allocation overwrites entry ptr (FIFO eviction); ptr wraps CHROWS-1 -> 0.
REQ-023 Lookup uses only tag equality with valid=1; duplicates never exist since a hit never allocates.
REQ-024 cRowId holds last value in IDLE.
REQ-025 Top stall SHALL be the OR of per-bank stall registers, no extra latency.

Reset
REQ-026 reset=1 at an edge: all states IDLE, all valid=0, ptr=0, cRowId=0, stall=0; overrides all other inputs, including mid-ALLOC.

Configuration
REQ-027 Macro MEM_SYNC_STATS_EN defined: add outputs hit_count[31:0] and miss_count[31:0], incremented on each IDLE->ACTIVE hit and IDLE->ALLOC miss across all banks (same-edge events summed), saturating at 2**32-1, cleared by reset.
REQ-028 Macro undefined: those ports and counters absent; all other behaviour identical.

Verification
REQ-029 Reset then bank[0][0] WRITE, RowId=0x1234 -> stall=1 one edge later, cRowId[0][0]=0; sync pulse on edge 4 -> stall=0 next edge.
REQ-030 Then BankFSM=0 one cycle, READ RowId=0x1234 -> no stall, cRowId[0][0]=0.
REQ-031 Sequential WRITE/sync/READ on all 16 banks, random RowIds -> each bank cRowId=0, stall raised only in each bank's ALLOC window.
REQ-032 bank[0][0] 63 further distinct rows -> cRowId 1..63; 65th distinct row -> cRowId=0 (eviction), old row 0x1234 now misses.
REQ-033 reset asserted mid-ALLOC -> stall=0, cRowId=0 next edge; re-access of prior rows misses.
REQ-034 sync pulsed in IDLE/ACTIVE -> no state, ptr or output change; with MEM_SYNC_STATS_EN, counts match hit/miss totals.
